instr_feeder: RTL and testbench

- Program sequencer that drives the processor's instruction port (DIN, Run) and consumes its Done handshake.
- Holds a small program RAM that is loaded through a write port.
- On Start, issues the stored words to the processor in order and inserts the immediate word for mvi in the right cycle.
- Stops at a halt opcode, and tracks completed and illegal instructions.

---
 rtl/instr_feeder.sv | 146 ++++++++++++++
 tb/tb_instr_feeder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_feeder.sv
// ============================================================================
// Module   : instr_feeder
// Purpose  : Program sequencer feeding a processor's DIN/Run port from a small
//            loadable RAM, honouring Done and a three-cycle watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_feeder #(
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          LdEn,
    input  logic [AW-1:0] LdAddr,
    input  logic [8:0]    LdData,
    input  logic          Start,
    input  logic          Done,
    output logic          Run,
    output logic [8:0]    DIN,
    output logic          Busy,
    output logic          Halted,
    output logic          Illegal,
    output logic [AW-1:0] PC,
    output logic [CW-1:0] InstrCount
);

    localparam logic [2:0] c_OP_MVI  = 3'b001;
    localparam logic [2:0] c_OP_HALT = 3'b111;
    localparam logic [1:0] c_WAIT_LAST = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [8:0]    r_mem [1<<AW];
    logic [2:0]    r_op;
    logic [1:0]    r_wcnt;
    logic [AW-1:0] r_pc;
    logic          r_illegal;
    logic [CW-1:0] r_count;

    logic [8:0]    w_word;
    logic          w_is_halt;
    logic          w_timeout;
    logic [CW-1:0] w_count_inc;

    assign w_word      = r_mem[r_pc];
    assign w_is_halt   = (w_word[8:6] == c_OP_HALT);
    // Third WAIT cycle ending without Done: illegal opcode or watchdog expiry
    assign w_timeout   = (r_wcnt == c_WAIT_LAST) && !Done;
    assign w_count_inc = (&r_count) ? r_count : r_count + CW'(1);

    assign Busy       = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign Halted     = (r_state == S_HALT);
    assign Illegal    = r_illegal;
    assign PC         = r_pc;
    assign InstrCount = r_count;

    always_ff @(posedge Clock) begin
        if (LdEn && !Busy) begin
            r_mem[LdAddr] <= LdData;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        Run         = 1'b0;
        DIN         = 9'd0;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (Start) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_is_halt) begin
                    w_state_nxt = S_HALT;
                end else begin
                    Run         = 1'b1;
                    DIN         = w_word;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Holds the mvi immediate while the processor is in T1
                DIN = w_word;
                if (Done || w_timeout) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state   <= S_IDLE;
            r_op      <= 3'd0;
            r_wcnt    <= 2'd0;
            r_pc      <= '0;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (Start) begin
                        r_pc      <= '0;
                        r_illegal <= 1'b0;
                        r_count   <= '0;
                    end
                end
                S_ISSUE: begin
                    if (!w_is_halt) begin
                        r_op   <= w_word[8:6];
                        r_pc   <= r_pc + AW'(1);
                        r_wcnt <= 2'd0;
                    end
                end
                S_WAIT: begin
                    r_wcnt <= r_wcnt + 2'd1;
                    if (Done) begin
                        r_count <= w_count_inc;
                        if (r_op == c_OP_MVI) begin
                            r_pc <= r_pc + AW'(1);
                        end
                    end else if (w_timeout) begin
                        r_illegal <= 1'b1;
                        r_count   <= w_count_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_feeder.sv
// ============================================================================
// Module   : tb_instr_feeder
// Purpose  : Self-checking bench for instr_feeder with a small processor
//            responder and a transaction-level program-walk reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_feeder;

    localparam int AW    = 5;
    localparam int CW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          Clock = 1'b0;
    logic          Resetn = 1'b0;
    logic          LdEn = 1'b0;
    logic [AW-1:0] LdAddr = '0;
    logic [8:0]    LdData = '0;
    logic          Start = 1'b0;
    logic          Done;
    logic          Run;
    logic [8:0]    DIN;
    logic          Busy;
    logic          Halted;
    logic          Illegal;
    logic [AW-1:0] PC;
    logic [CW-1:0] InstrCount;

    int tests = 0;
    int fails = 0;

    instr_feeder #(.AW(AW), .CW(CW)) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .LdEn       (LdEn),
        .LdAddr     (LdAddr),
        .LdData     (LdData),
        .Start      (Start),
        .Done       (Done),
        .Run        (Run),
        .DIN        (DIN),
        .Busy       (Busy),
        .Halted     (Halted),
        .Illegal    (Illegal),
        .PC         (PC),
        .InstrCount (InstrCount)
    );

    always #5 Clock = ~Clock;

    // Processor stand-in: mv/mvi answer Done in T1, add/sub in T3, 100-110 never
    logic       sup = 1'b0;
    logic [2:0] p_op;
    int         p_step;

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            p_op   <= 3'd0;
            p_step <= 0;
        end else if (Run) begin
            p_op   <= DIN[8:6];
            p_step <= 1;
        end else if (p_step != 0) begin
            p_step <= (p_step == 3) ? 0 : p_step + 1;
        end
    end

    assign Done = !sup && ((p_step == 1 && p_op[2:1] == 2'b00) ||
                           (p_step == 3 && p_op[2:1] == 2'b01));

    typedef struct packed {
        logic [5:0][8:0] w;
        logic [3:0]      n;
        logic [15:0]     run_mask;
        logic [8:0]      din2;
        logic [7:0]      hc;
        logic [15:0]     cnt;
        logic [4:0]      pc;
        logic            ill;
        logic            sup;
    } vec_t;

    vec_t vecs [7];

    logic [8:0] ref_mem [DEPTH];
    int         exp_cyc [$];
    logic [8:0] exp_din [$];
    int         exp_hc;
    int         exp_cnt;
    int         exp_pc;
    bit         exp_ill;

    function automatic vec_t mk(input logic [8:0] a, b, c, d, e, f, input int n,
                                input logic [15:0] mask, input logic [8:0] din2,
                                input int hc, cnt, pc, input bit ill, s);
        vec_t v;
        v.w = {f, e, d, c, b, a};
        v.n = 4'(n);
        v.run_mask = mask;
        v.din2 = din2;
        v.hc = 8'(hc);
        v.cnt = 16'(cnt);
        v.pc = 5'(pc);
        v.ill = ill;
        v.sup = s;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic load(input int addr, input logic [8:0] data);
        @(negedge Clock);
        LdEn = 1'b1;
        LdAddr = AW'(addr);
        LdData = data;
        ref_mem[addr] = data;
        @(posedge Clock);
        #1 LdEn = 1'b0;
    endtask

    task automatic pulse_start;
        @(negedge Clock);
        Start = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
    endtask

    task automatic apply_vec(input int i, input bit do_load);
        vec_t v = vecs[i];
        if (do_load) begin
            for (int k = 0; k < int'(v.n); k++) load(k, v.w[k]);
        end
        sup = v.sup;
        pulse_start();
        for (int c = 1; c <= int'(v.hc); c++) begin
            @(negedge Clock);
            chk($sformatf("v%0d run c%0d", i, c), 32'(Run), 32'(v.run_mask[c]));
            if (c == 1) chk($sformatf("v%0d count clr", i), 32'(InstrCount), 32'd0);
            if (c == 2) chk($sformatf("v%0d din c2", i), 32'(DIN), 32'(v.din2));
            if (c == int'(v.hc) - 1) chk($sformatf("v%0d not halted", i), 32'(Halted), 32'd0);
            if (c == int'(v.hc)) begin
                chk($sformatf("v%0d halted", i), 32'(Halted), 32'd1);
                chk($sformatf("v%0d count", i), 32'(InstrCount), 32'(v.cnt));
                chk($sformatf("v%0d pc", i), 32'(PC), 32'(v.pc));
                chk($sformatf("v%0d illegal", i), 32'(Illegal), 32'(v.ill));
            end
        end
        sup = 1'b0;
    endtask

    // Walks the stored program instruction by instruction, costing each by its latency
    task automatic model_run(input bit s);
        int pc, cyc, cnt;
        bit ill;
        logic [8:0] w;
        logic [2:0] op;
        pc = 0; cyc = 1; cnt = 0; ill = 0;
        exp_cyc.delete();
        exp_din.delete();
        for (int k = 0; k < 200; k++) begin
            w = ref_mem[pc];
            op = w[8:6];
            if (op == 3'd7) break;
            exp_cyc.push_back(cyc);
            exp_din.push_back(w);
            if (!s && op <= 3'd3) begin
                cyc += (op <= 3'd1) ? 2 : 4;
                pc = (pc + ((op == 3'd1) ? 2 : 1)) % DEPTH;
            end else begin
                cyc += 4;
                ill = 1;
                pc = (pc + 1) % DEPTH;
            end
            cnt++;
        end
        exp_hc = cyc + 1;
        exp_cnt = cnt;
        exp_pc = pc;
        exp_ill = ill;
    endtask

    task automatic random_prog(input int t);
        int L, pos, idx;
        logic [2:0] op;
        bit s;
        L = $urandom_range(2, 28);
        pos = 0;
        while (pos < L) begin
            op = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 6)) : 3'($urandom_range(0, 3));
            load(pos, {op, 6'($urandom)});
            pos++;
            if (op == 3'd1) begin
                load(pos, 9'($urandom));
                pos++;
            end
        end
        load(pos, {3'b111, 6'($urandom)});
        s = ($urandom_range(0, 3) == 0);
        model_run(s);
        sup = s;
        pulse_start();
        idx = 0;
        for (int c = 1; c <= exp_hc; c++) begin
            bit er;
            @(negedge Clock);
            er = (idx < exp_cyc.size()) && (exp_cyc[idx] == c);
            chk($sformatf("r%0d run c%0d", t, c), 32'(Run), 32'(er));
            if (er) begin
                chk($sformatf("r%0d din c%0d", t, c), 32'(DIN), 32'(exp_din[idx]));
                idx++;
            end
            chk($sformatf("r%0d busy c%0d", t, c), 32'(Busy), 32'(c < exp_hc));
            if (c == exp_hc) begin
                chk($sformatf("r%0d halted", t), 32'(Halted), 32'd1);
                chk($sformatf("r%0d count", t), 32'(InstrCount), 32'(exp_cnt));
                chk($sformatf("r%0d pc", t), 32'(PC), 32'(exp_pc));
                chk($sformatf("r%0d illegal", t), 32'(Illegal), 32'(exp_ill));
            end
        end
        sup = 1'b0;
    endtask

    initial begin
        vecs[0] = mk(9'h040, 9'h005, 9'h048, 9'h003, 9'h081, 9'h1C0, 6, 16'h002A, 9'h005, 10, 3, 5, 0, 0);
        vecs[1] = mk(9'h000, 9'h0C1, 9'h1C0, 9'h0, 9'h0, 9'h0, 3, 16'h000A, 9'h0C1, 8, 2, 2, 0, 0);
        vecs[2] = mk(9'h100, 9'h1C0, 9'h0, 9'h0, 9'h0, 9'h0, 2, 16'h0002, 9'h1C0, 6, 1, 1, 1, 0);
        vecs[3] = mk(9'h1C0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 1, 16'h0000, 9'h000, 2, 0, 0, 0, 0);
        vecs[4] = mk(9'h0C1, 9'h1C0, 9'h0, 9'h0, 9'h0, 9'h0, 2, 16'h0002, 9'h1C0, 6, 1, 1, 0, 0);
        vecs[5] = mk(9'h040, 9'h1C0, 9'h1C0, 9'h0, 9'h0, 9'h0, 3, 16'h0002, 9'h1C0, 4, 1, 2, 0, 0);
        vecs[6] = mk(9'h000, 9'h1C0, 9'h0, 9'h0, 9'h0, 9'h0, 2, 16'h0002, 9'h1C0, 6, 1, 1, 1, 1);

        repeat (2) @(negedge Clock);
        chk("rst run", 32'(Run), 32'd0);
        chk("rst din", 32'(DIN), 32'd0);
        chk("rst busy", 32'(Busy), 32'd0);
        chk("rst halted", 32'(Halted), 32'd0);
        chk("rst pc", 32'(PC), 32'd0);
        chk("rst illegal", 32'(Illegal), 32'd0);
        chk("rst count", 32'(InstrCount), 32'd0);
        Resetn = 1'b1;

        for (int i = 0; i < 7; i++) apply_vec(i, 1'b1);

        for (int t = 0; t < 20; t++) random_prog(t);

        // Start and write together from idle: first issue sees the new word
        @(negedge Clock);
        Start = 1'b1; LdEn = 1'b1; LdAddr = '0; LdData = 9'h1C0;
        ref_mem[0] = 9'h1C0;
        @(posedge Clock);
        #1 Start = 1'b0; LdEn = 1'b0;
        @(negedge Clock);
        chk("same-cycle c1 run", 32'(Run), 32'd0);
        chk("same-cycle c1 busy", 32'(Busy), 32'd1);
        @(negedge Clock);
        chk("same-cycle halted", 32'(Halted), 32'd1);

        // Start and LdEn during WAIT are ignored
        for (int k = 0; k < 6; k++) load(k, vecs[0].w[k]);
        pulse_start();
        for (int c = 1; c <= 10; c++) begin
            @(negedge Clock);
            if (c == 2) begin
                Start = 1'b1; LdEn = 1'b1; LdAddr = '0; LdData = 9'h1C0;
                @(posedge Clock);
                #1 Start = 1'b0; LdEn = 1'b0;
            end
            if (c == 3) chk("busy-ign run c3", 32'(Run), 32'd1);
            if (c == 10) begin
                chk("busy-ign halted", 32'(Halted), 32'd1);
                chk("busy-ign count", 32'(InstrCount), 32'd3);
            end
        end
        apply_vec(0, 1'b0);

        // Reset in the second WAIT cycle of the add
        pulse_start();
        repeat (7) @(negedge Clock);
        chk("mid-add busy before", 32'(Busy), 32'd1);
        Resetn = 1'b0;
        #1;
        chk("mid-add rst run", 32'(Run), 32'd0);
        chk("mid-add rst din", 32'(DIN), 32'd0);
        chk("mid-add rst pc", 32'(PC), 32'd0);
        chk("mid-add rst busy", 32'(Busy), 32'd0);
        chk("mid-add rst halted", 32'(Halted), 32'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        apply_vec(0, 1'b0);

        // mvi at the last address takes its immediate from address 0
        for (int k = 0; k < DEPTH - 1; k++) load(k, 9'h000);
        load(DEPTH - 1, 9'h040);
        pulse_start();
        begin
            bit found;
            found = 0;
            for (int c = 0; c < 200 && !found; c++) begin
                @(negedge Clock);
                if (Run && DIN == 9'h040) found = 1;
            end
            chk("wrap mvi reached", 32'(found), 32'd1);
            if (found) begin
                chk("wrap mvi pc", 32'(PC), 32'(DEPTH - 1));
                @(negedge Clock);
                chk("wrap imm din", 32'(DIN), 32'h000);
                chk("wrap imm pc", 32'(PC), 32'd0);
                @(negedge Clock);
                chk("wrap next run", 32'(Run), 32'd1);
                chk("wrap next pc", 32'(PC), 32'd1);
                #1 Resetn = 1'b0;
                #1;
                chk("wrap rst run", 32'(Run), 32'd0);
                chk("wrap rst busy", 32'(Busy), 32'd0);
                chk("wrap rst pc", 32'(PC), 32'd0);
            end
        end
        @(negedge Clock);
        Resetn = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
